// File: rtl/regfile_scoreboard.sv
// Parametrised register file with two async read ports, one write port,
// and a per-register pending scoreboard for hazard detection.
module regfile_scoreboard #(
    parameter int WIDTH   = 32,
    parameter int ADDR_W  = 5,
    parameter int DEPTH   = 32,
    parameter bit ZERO_R0 = 1'b1,
    parameter bit BYPASS  = 1'b1
) (
    input  logic              in_clk,
    input  logic              in_reset,
    input  logic [WIDTH-1:0]  in_PC,
    input  logic [ADDR_W-1:0] in_SC,
    input  logic              in_RFL,
    input  logic [ADDR_W-1:0] in_SA,
    input  logic [ADDR_W-1:0] in_SB,
    output logic [WIDTH-1:0]  out_PA,
    output logic [WIDTH-1:0]  out_PB,
    input  logic              in_RSV,
    input  logic [ADDR_W-1:0] in_SR,
    output logic              out_busyA,
    output logic              out_busyB,
    output logic [ADDR_W:0]   out_pending
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0] r_pend;
    logic [ADDR_W:0]  r_count;

    logic w_wr_ok;
    logic w_rsv_ok;
    logic w_inc;
    logic w_dec;
    logic w_byp_a;
    logic w_byp_b;

    // Selects past DEPTH and a hardwired R0 are never real storage.
    function automatic logic f_legal(input logic [ADDR_W-1:0] sel);
        f_legal = ({1'b0, sel} < (ADDR_W+1)'(DEPTH))
                  && !(ZERO_R0 && (sel == '0));
    endfunction

    assign w_wr_ok  = in_RFL && !in_reset && f_legal(in_SC);
    assign w_rsv_ok = in_RSV && !in_reset && f_legal(in_SR);
    assign w_byp_a  = BYPASS && w_wr_ok && (in_SC == in_SA);
    assign w_byp_b  = BYPASS && w_wr_ok && (in_SC == in_SB);

    assign w_inc = w_rsv_ok && !r_pend[in_SR[IW-1:0]];
    assign w_dec = w_wr_ok && r_pend[in_SC[IW-1:0]]
                   && !(w_rsv_ok && (in_SR == in_SC));

    always_comb begin
        out_PA    = '0;
        out_PB    = '0;
        out_busyA = 1'b0;
        out_busyB = 1'b0;
        if (f_legal(in_SA)) begin
            out_PA    = r_regs[in_SA[IW-1:0]];
            out_busyA = r_pend[in_SA[IW-1:0]];
        end
        if (f_legal(in_SB)) begin
            out_PB    = r_regs[in_SB[IW-1:0]];
            out_busyB = r_pend[in_SB[IW-1:0]];
        end
        // Forwarded data is already final, so the hazard is gone.
        if (w_byp_a) begin
            out_PA    = in_PC;
            out_busyA = 1'b0;
        end
        if (w_byp_b) begin
            out_PB    = in_PC;
            out_busyB = 1'b0;
        end
    end

    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_pend  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_ok) begin
                r_regs[in_SC[IW-1:0]] <= in_PC;
                r_pend[in_SC[IW-1:0]] <= 1'b0;
            end
            // A new producer supersedes a same-edge writeback.
            if (w_rsv_ok) begin
                r_pend[in_SR[IW-1:0]] <= 1'b1;
            end
            r_count <= r_count + (ADDR_W+1)'(w_inc)
                               - (ADDR_W+1)'(w_dec);
        end
    end

    assign out_pending = r_count;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: vector table through a scoreboard queue,
// plus hand sequences for no-bypass, bounds and mid-cycle reset.
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [4:0]  sc, sa, sb, sr;
    logic        rfl, rsv;
    logic [31:0] pa, pb;
    logic        ba, bb;
    logic [5:0]  pend;

    logic [31:0] n_pc;
    logic [4:0]  n_sc, n_sa, n_sb, n_sr;
    logic        n_rfl, n_rsv;
    logic [31:0] n_pa, n_pb;
    logic        n_ba, n_bb;
    logic [5:0]  n_pend;

    int checks = 0;
    int errors = 0;

    regfile_scoreboard u_dut (
        .in_clk(clk), .in_reset(rst),
        .in_PC(pc), .in_SC(sc), .in_RFL(rfl),
        .in_SA(sa), .in_SB(sb),
        .out_PA(pa), .out_PB(pb),
        .in_RSV(rsv), .in_SR(sr),
        .out_busyA(ba), .out_busyB(bb),
        .out_pending(pend)
    );

    regfile_scoreboard #(
        .DEPTH(24), .ZERO_R0(1'b0), .BYPASS(1'b0)
    ) u_nb (
        .in_clk(clk), .in_reset(rst),
        .in_PC(n_pc), .in_SC(n_sc), .in_RFL(n_rfl),
        .in_SA(n_sa), .in_SB(n_sb),
        .out_PA(n_pa), .out_PB(n_pb),
        .in_RSV(n_rsv), .in_SR(n_sr),
        .out_busyA(n_ba), .out_busyB(n_bb),
        .out_pending(n_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rfl;
        logic [4:0]  sc;
        logic [31:0] pc;
        logic [4:0]  sa;
        logic [4:0]  sb;
        logic        rsv;
        logic [4:0]  sr;
        logic [31:0] pa;
        logic [31:0] pb;
        logic        ba;
        logic        bb;
        logic [5:0]  pend;
    } vec_t;

    vec_t tbl[17];
    vec_t q[$];

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic n_idle();
        n_rfl = 0; n_rsv = 0; n_pc = '0;
        n_sc = '0; n_sr = '0; n_sa = '0; n_sb = '0;
    endtask

    initial begin
        vec_t e;
        // rfl sc pc sa sb rsv sr | pa pb ba bb pend
        tbl[0]  = '{0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 4, 32'h4,        4, 3, 0, 0, 32'h4, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0,            4, 3, 0, 0, 32'h4, 0, 0, 0, 0};
        tbl[3]  = '{1, 3, 32'hFFFFFFFF, 3, 4, 0, 0,
                    32'hFFFFFFFF, 32'h4, 0, 0, 0};
        tbl[4]  = '{0, 0, 0,            3, 3, 0, 0,
                    32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0};
        tbl[5]  = '{1, 0, 32'hDEADBEEF, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        tbl[6]  = '{0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[7]  = '{0, 0, 0,            5, 7, 1, 5, 0, 0, 0, 0, 0};
        tbl[8]  = '{0, 0, 0,            5, 7, 1, 7, 0, 0, 1, 0, 1};
        tbl[9]  = '{0, 0, 0,            5, 7, 0, 0, 0, 0, 1, 1, 2};
        tbl[10] = '{1, 5, 32'h55,       5, 7, 0, 0, 32'h55, 0, 0, 1, 2};
        tbl[11] = '{0, 0, 0,            5, 7, 0, 0, 32'h55, 0, 0, 1, 1};
        tbl[12] = '{1, 7, 32'h77,       7, 5, 1, 7, 32'h77, 32'h55, 0, 0, 1};
        tbl[13] = '{0, 0, 0,            7, 5, 0, 0, 32'h77, 32'h55, 1, 0, 1};
        tbl[14] = '{0, 0, 0,            7, 5, 1, 7, 32'h77, 32'h55, 1, 0, 1};
        tbl[15] = '{1, 7, 32'h700,      7, 5, 1, 5, 32'h700, 32'h55, 0, 0, 1};
        tbl[16] = '{0, 0, 0,            7, 5, 0, 0, 32'h700, 32'h55, 0, 1, 1};

        rst = 1; rfl = 0; rsv = 0; pc = '0;
        sc = '0; sa = '0; sb = '0; sr = '0;
        n_idle();
        repeat (2) @(posedge clk);
        #1;
        check("rst_pa", pa, 0);
        check("rst_pend", {26'd0, pend}, 0);
        rst = 0;

        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            rfl = tbl[i].rfl; sc = tbl[i].sc; pc = tbl[i].pc;
            sa = tbl[i].sa; sb = tbl[i].sb;
            rsv = tbl[i].rsv; sr = tbl[i].sr;
            q.push_back(tbl[i]);
            @(negedge clk);
            e = q.pop_front();
            check($sformatf("v%0d_pa", i), pa, e.pa);
            check($sformatf("v%0d_pb", i), pb, e.pb);
            check($sformatf("v%0d_ba", i), {31'd0, ba}, {31'd0, e.ba});
            check($sformatf("v%0d_bb", i), {31'd0, bb}, {31'd0, e.bb});
            check($sformatf("v%0d_pend", i),
                  {26'd0, pend}, {26'd0, e.pend});
        end
        @(posedge clk);
        #1;
        rfl = 0; rsv = 0;

        // No-bypass instance: DEPTH 24, writable R0
        n_rfl = 1; n_sc = 3; n_pc = 32'hFFFFFFFF; n_sa = 3;
        @(negedge clk);
        check("nb_old", n_pa, 0);
        @(posedge clk); #1;
        n_idle(); n_sa = 3;
        @(negedge clk);
        check("nb_new", n_pa, 32'hFFFFFFFF);
        @(posedge clk); #1;
        n_rfl = 1; n_sc = 0; n_pc = 32'hDEADBEEF;
        @(posedge clk); #1;
        n_idle(); n_sa = 0;
        @(negedge clk);
        check("nb_r0", n_pa, 32'hDEADBEEF);
        @(posedge clk); #1;
        n_rfl = 1; n_sc = 25; n_pc = 32'h1234;
        n_rsv = 1; n_sr = 25;
        @(posedge clk); #1;
        n_idle(); n_sa = 25; n_sb = 25;
        @(negedge clk);
        check("nb_oob_pa", n_pa, 0);
        check("nb_oob_busy", {31'd0, n_ba}, 0);
        check("nb_oob_pend", {26'd0, n_pend}, 0);
        @(posedge clk); #1;
        n_rfl = 1; n_sc = 23; n_pc = 32'h23;
        n_rsv = 1; n_sr = 0;
        @(posedge clk); #1;
        n_idle(); n_sa = 23; n_sb = 0;
        @(negedge clk);
        check("nb_r23", n_pa, 32'h23);
        check("nb_busy0", {31'd0, n_bb}, 1);
        check("nb_pend1", {26'd0, n_pend}, 1);
        @(posedge clk); #1;
        n_rfl = 1; n_sc = 0; n_pc = 32'h0A; n_sb = 0;
        @(negedge clk);
        check("nb_nomask", {31'd0, n_bb}, 1);
        check("nb_noforward", n_pb, 32'hDEADBEEF);
        @(posedge clk); #1;
        n_idle();
        @(negedge clk);
        check("nb_clr_busy", {31'd0, n_bb}, 0);
        check("nb_clr_pend", {26'd0, n_pend}, 0);
        check("nb_clr_data", n_pb, 32'h0A);

        // Mid-cycle asynchronous reset
        @(posedge clk); #1;
        sa = 5; sb = 3;
        @(negedge clk);
        check("pre_rst_pa", pa, 32'h55);
        check("pre_rst_busy", {31'd0, ba}, 1);
        #2 rst = 1;
        #1;
        check("arst_pa", pa, 0);
        check("arst_pb", pb, 0);
        check("arst_ba", {31'd0, ba}, 0);
        check("arst_pend", {26'd0, pend}, 0);
        rfl = 1; sc = 5; pc = 32'h99;
        rsv = 1; sr = 6;
        #1;
        check("arst_nobyp", pa, 0);
        @(posedge clk); #1;
        check("arst_hold_pa", pa, 0);
        check("arst_hold_pend", {26'd0, pend}, 0);
        #2 rst = 0;
        rsv = 0; rfl = 1; sc = 6; pc = 32'h66; sa = 6; sb = 5;
        #1;
        check("post_rst_byp", pa, 32'h66);
        @(posedge clk); #1;
        rfl = 0;
        @(negedge clk);
        check("post_rst_wr", pa, 32'h66);
        check("post_rst_r5", pb, 0);
        check("post_rst_pend", {26'd0, pend}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
